// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: FSM state encodings and the
// instruction-set opcode fields it decodes.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } fetchState_e;

   // Major opcode lives in instr[15:12]; bit 11 selects Z/N for conditional branches.
   localparam logic [3:0] OP_ADD     = 4'h1;
   localparam logic [3:0] OP_BR      = 4'h3;
   localparam logic [3:0] OP_BR_COND = 4'h4;
   localparam logic [3:0] OP_BR_SUB  = 4'h5;
   localparam logic [3:0] OP_RETURN  = 4'h6;

   localparam logic [4:0] OP_BR_Z = {OP_BR_COND, 1'b0};
   localparam logic [4:0] OP_BR_N = {OP_BR_COND, 1'b1};

   function automatic logic [3:0] opMajor(input logic [15:0] word);
      return word[15:12];
   endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// DEPTH must be a power of two so the pointer wraps naturally.
module return_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] pushData,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW:0]   count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (push) begin
         mem[wrPtr] <= pushData;
         wrPtr      <= wrPtr + AW'(1);
         if (count != FULL_CNT) count <= count + (AW + 1)'(1);
      end else if (pop && !empty) begin
         wrPtr <= wrPtr - AW'(1);
         count <= count - (AW + 1)'(1);
      end
   end

   assign top   = mem[wrPtr - AW'(1)];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer feeding the control unit.
// Define FETCH_RAS_EN for a RAS_DEPTH-entry return stack; otherwise a single temp register.
//
// state    | meaning
// ST_IDLE  | waiting for run
// ST_FETCH | imem_req high, waiting for imem_ack
// ST_ISSUE | instr_valid high, waiting for instr_ready; PC updates on handshake
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [15:0]     instr,
   output logic [4:0]      op_out,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            pc_line,
   input  logic            we_temp,
   input  logic            flag_z,
   input  logic            flag_n,
   output logic [PC_W-1:0] pc_out,
   output logic            ras_fault
);

   fetchState_e     state, stateNext;
   logic [PC_W-1:0] pc, pcNext, pcInc, tgt, retAddr, pcOutReg;
   logic [15:0]     instrReg;
   logic            handshake, isReturn, condTrue, doPush, doPop;

   assign handshake = (state == ST_ISSUE) && instr_ready;
   assign isReturn  = (opMajor(instrReg) == OP_RETURN);
   assign doPop     = handshake && isReturn;
   assign doPush    = handshake && !isReturn && we_temp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         pc       <= '0;
         instrReg <= '0;
         pcOutReg <= '0;
      end else begin
         state <= stateNext;
         if (state == ST_FETCH && imem_ack) begin
            instrReg <= imem_rdata;
            pcOutReg <= pc;
         end
         if (handshake) pc <= pcNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         ST_IDLE:  if (run)         stateNext = ST_FETCH;
         ST_FETCH: if (imem_ack)    stateNext = ST_ISSUE;
         ST_ISSUE: if (instr_ready) stateNext = ST_FETCH;
         default:                   stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      pcInc    = pc + PC_W'(1);
      tgt      = instrReg[PC_W-1:0];
      condTrue = instrReg[11] ? flag_n : flag_z;
      pcNext   = pcInc;
      if (isReturn)                          pcNext = retAddr;
      else if (we_temp)                      pcNext = tgt;
      else if (opMajor(instrReg) == OP_BR)   pcNext = tgt;
      else if (!pc_line)                     pcNext = condTrue ? tgt : pcInc;
   end

`ifdef FETCH_RAS_EN
   logic [PC_W-1:0] retTop;
   logic            rasEmpty, rasFaultReg;

   return_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_returnStack (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (doPush),
      .pop      (doPop),
      .pushData (pcInc),
      .top      (retTop),
      .empty    (rasEmpty),
      .full     ()
   );

   // Popping an empty stack restarts at address 0 and flags the underflow.
   assign retAddr = rasEmpty ? '0 : retTop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rasFaultReg <= 1'b0;
      else          rasFaultReg <= doPop && rasEmpty;
   end

   assign ras_fault = rasFaultReg;
`else
   logic [PC_W-1:0] tempReg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    tempReg <= '0;
      else if (doPush) tempReg <= pcInc;
   end

   assign retAddr   = tempReg;
   assign ras_fault = 1'b0;
`endif

   assign imem_req    = (state == ST_FETCH);
   assign instr_valid = (state == ST_ISSUE);
   assign imem_addr   = pc;
   assign instr       = instrReg;
   assign op_out      = instrReg[15:11];
   assign pc_out      = pcOutReg;

endmodule
